// File: rtl/rd_lane_sched.sv
// Read-return scheduler: releases lane FIFO pops only when a beat is owed and all lanes hold data.
// Supervises lane skew, return timeout and outstanding overflow; any error flushes the FIFOs.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | no read beats outstanding
// S_ACTIVE | beats outstanding, pops allowed when all lanes ready
// S_ERROR  | sticky error latched, FIFOs flushed until clr_err
module rd_lane_sched #(
   parameter int  IOG_DQS_LANES   = 2,
   parameter int  MAX_OUTSTANDING = 8,
   parameter int  SKEW_LIMIT      = 16,
   parameter int  TIMEOUT_CYCLES  = 64,
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                     SCLK,
   input  logic                     reset_n,
   input  logic                     dfi_rddata_en,
   input  logic [IOG_DQS_LANES-1:0] entries_in_FIFO_N,
   input  logic                     clr_err,
   output logic                     read_FIFO_en,
   output logic                     dfi_rddata_valid,
   output logic                     fifo_flush,
   output logic [CNT_W-1:0]         outstanding,
   output logic                     skew_err,
   output logic                     timeout_err,
   output logic                     ovf_err
);

   localparam int SKW_W = $clog2(SKEW_LIMIT + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_ERROR  = 2'd2
   } state_t;

   state_t           state;
   logic [SKW_W-1:0] skew_tmr;
   logic [TMO_W-1:0] tmo_tmr;
   logic [CNT_W-1:0] cnt_nxt;
   logic             all_rdy;
   logic             any_rdy;
   logic             push;
   logic             pop;
   logic             skew_cond;
   logic             tmo_cond;
   logic             skew_hit;
   logic             tmo_hit;
   logic             ovf_hit;
   logic             err_hit;

   assign all_rdy      = &entries_in_FIFO_N;
   assign any_rdy      = |entries_in_FIFO_N;
   assign read_FIFO_en = (state == S_ACTIVE) && all_rdy;
   assign pop          = read_FIFO_en;
   assign push         = dfi_rddata_en && (state != S_ERROR);

   // Timers hold the number of qualifying cycles left before the limit trips.
   assign skew_cond = any_rdy && !all_rdy && (state != S_ERROR);
   assign tmo_cond  = (state == S_ACTIVE) && !pop;
   assign skew_hit  = skew_cond && (skew_tmr == SKW_W'(1));
   assign tmo_hit   = tmo_cond && (tmo_tmr == TMO_W'(1));
   assign ovf_hit   = push && !pop && (outstanding == CNT_W'(MAX_OUTSTANDING));
   assign err_hit   = skew_hit || tmo_hit || ovf_hit;

   always_comb begin
      cnt_nxt = outstanding;
      if (push && !pop && !ovf_hit)
         cnt_nxt = outstanding + CNT_W'(1);
      else if (pop && !push)
         cnt_nxt = outstanding - CNT_W'(1);
   end

   always_ff @(posedge SCLK or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         outstanding      <= '0;
         dfi_rddata_valid <= 1'b0;
         fifo_flush       <= 1'b0;
         skew_err         <= 1'b0;
         timeout_err      <= 1'b0;
         ovf_err          <= 1'b0;
         skew_tmr         <= SKW_W'(SKEW_LIMIT);
         tmo_tmr          <= TMO_W'(TIMEOUT_CYCLES);
      end else begin
         dfi_rddata_valid <= read_FIFO_en;
         case (state)
            S_ERROR: begin
               skew_tmr <= SKW_W'(SKEW_LIMIT);
               tmo_tmr  <= TMO_W'(TIMEOUT_CYCLES);
               if (clr_err) begin
                  state       <= S_IDLE;
                  outstanding <= '0;
                  fifo_flush  <= 1'b0;
                  skew_err    <= 1'b0;
                  timeout_err <= 1'b0;
                  ovf_err     <= 1'b0;
               end
            end
            default: begin
               outstanding <= cnt_nxt;
               skew_tmr    <= skew_cond ? skew_tmr - SKW_W'(1) : SKW_W'(SKEW_LIMIT);
               tmo_tmr     <= tmo_cond ? tmo_tmr - TMO_W'(1) : TMO_W'(TIMEOUT_CYCLES);
               if (err_hit) begin
                  state       <= S_ERROR;
                  fifo_flush  <= 1'b1;
                  skew_err    <= skew_hit;
                  timeout_err <= tmo_hit;
                  ovf_err     <= ovf_hit;
               end else if (cnt_nxt == '0) begin
                  state <= S_IDLE;
               end else begin
                  state <= S_ACTIVE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rd_lane_sched.sv
// Bench for rd_lane_sched: fixed vector table, directed corner sequences and random traffic
// compared against an age-counting reference model of the scheduling and error rules.
module tb_rd_lane_sched;

   localparam int LANES    = 2;
   localparam int MAX_OUT  = 8;
   localparam int SKEW_LIM = 16;
   localparam int TMO_LIM  = 64;
   localparam int CW       = 4;

   logic            SCLK;
   logic            reset_n;
   logic            dfi_rddata_en;
   logic [LANES-1:0] entries_in_FIFO_N;
   logic            clr_err;
   logic            read_FIFO_en;
   logic            dfi_rddata_valid;
   logic            fifo_flush;
   logic [CW-1:0]   outstanding;
   logic            skew_err;
   logic            timeout_err;
   logic            ovf_err;

   rd_lane_sched #(
      .IOG_DQS_LANES  (LANES),
      .MAX_OUTSTANDING(MAX_OUT),
      .SKEW_LIMIT     (SKEW_LIM),
      .TIMEOUT_CYCLES (TMO_LIM)
   ) dut (
      .SCLK             (SCLK),
      .reset_n          (reset_n),
      .dfi_rddata_en    (dfi_rddata_en),
      .entries_in_FIFO_N(entries_in_FIFO_N),
      .clr_err          (clr_err),
      .read_FIFO_en     (read_FIFO_en),
      .dfi_rddata_valid (dfi_rddata_valid),
      .fifo_flush       (fifo_flush),
      .outstanding      (outstanding),
      .skew_err         (skew_err),
      .timeout_err      (timeout_err),
      .ovf_err          (ovf_err)
   );

   initial SCLK = 1'b0;
   always #5 SCLK = ~SCLK;

   int n_vec;
   int n_err;
   int vld_cnt;
   bit rd_seen;

   // reference model: beats owed, sticky flags, and how long each hazard has persisted
   int m_out;
   int m_skew_age;
   int m_tmo_age;
   bit m_skew, m_tmo, m_ovf, m_valid, m_flush;

   typedef struct {
      logic       en;
      logic [1:0] lanes;
      logic       clr;
      logic       rd;
      logic       vld;
      logic [3:0] out;
      logic       flush;
      logic [2:0] errs;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_out = 0; m_skew_age = 0; m_tmo_age = 0;
      m_skew = 0; m_tmo = 0; m_ovf = 0; m_valid = 0; m_flush = 0;
   endtask

   function automatic bit model_pop(input logic [1:0] lanes);
      return !(m_skew || m_tmo || m_ovf) && (m_out > 0) && (lanes == 2'b11);
   endfunction

   task automatic model_update(input bit en, input logic [1:0] lanes, input bit clr, input bit pop);
      bit in_err;
      in_err = m_skew || m_tmo || m_ovf;
      if (in_err) begin
         if (clr) begin
            m_out = 0; m_skew = 0; m_tmo = 0; m_ovf = 0;
         end
         m_skew_age = 0;
         m_tmo_age  = 0;
      end else begin
         if (lanes == 2'b01 || lanes == 2'b10) m_skew_age++; else m_skew_age = 0;
         if (m_out > 0 && !pop) m_tmo_age++; else m_tmo_age = 0;
         if (m_skew_age == SKEW_LIM) m_skew = 1;
         if (m_tmo_age == TMO_LIM) m_tmo = 1;
         if (en && !pop) begin
            if (m_out == MAX_OUT) m_ovf = 1;
            else m_out++;
         end else if (pop && !en) begin
            m_out--;
         end
         if (m_skew || m_tmo || m_ovf) begin
            m_skew_age = 0;
            m_tmo_age  = 0;
         end
      end
      m_valid = pop;
      m_flush = m_skew || m_tmo || m_ovf;
   endtask

   // one clock against the model; entered and left at posedge+1
   task automatic cyc(input bit en, input logic [1:0] lanes, input bit clr);
      bit p;
      dfi_rddata_en = en; entries_in_FIFO_N = lanes; clr_err = clr;
      #2;
      p = model_pop(lanes);
      chk("read_FIFO_en", {31'd0, read_FIFO_en}, {31'd0, p});
      if (read_FIFO_en) rd_seen = 1;
      model_update(en, lanes, clr, p);
      @(posedge SCLK); #1;
      if (dfi_rddata_valid) vld_cnt++;
      chk("dfi_rddata_valid", {31'd0, dfi_rddata_valid}, {31'd0, m_valid});
      chk("fifo_flush", {31'd0, fifo_flush}, {31'd0, m_flush});
      chk("outstanding", {28'd0, outstanding}, m_out);
      chk("skew_err", {31'd0, skew_err}, {31'd0, m_skew});
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_tmo});
      chk("ovf_err", {31'd0, ovf_err}, {31'd0, m_ovf});
   endtask

   task automatic apply_vec(input vec_t v);
      bit p;
      dfi_rddata_en = v.en; entries_in_FIFO_N = v.lanes; clr_err = v.clr;
      #2;
      chk("tbl_read_FIFO_en", {31'd0, read_FIFO_en}, {31'd0, v.rd});
      p = model_pop(v.lanes);
      model_update(v.en, v.lanes, v.clr, p);
      @(posedge SCLK); #1;
      chk("tbl_valid", {31'd0, dfi_rddata_valid}, {31'd0, v.vld});
      chk("tbl_outstanding", {28'd0, outstanding}, {28'd0, v.out});
      chk("tbl_flush", {31'd0, fifo_flush}, {31'd0, v.flush});
      chk("tbl_errs", {29'd0, skew_err, timeout_err, ovf_err}, {29'd0, v.errs});
   endtask

   task automatic do_reset();
      dfi_rddata_en = 0; entries_in_FIFO_N = '0; clr_err = 0;
      reset_n = 0;
      model_reset();
      @(posedge SCLK); #1;
      reset_n = 1;
   endtask

   initial begin
      n_vec = 0; n_err = 0; vld_cnt = 0; rd_seen = 0;
      reset_n = 0; dfi_rddata_en = 0; entries_in_FIFO_N = '0; clr_err = 0;
      model_reset();

      //            en    lanes  clr   rd    vld   out   flush errs
      tbl[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 3'b000};
      tbl[1]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 3'b000};
      tbl[2]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 3'b000};
      tbl[3]  = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 3'b000};
      tbl[4]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000};
      tbl[5]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000};
      tbl[6]  = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000};
      tbl[7]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 3'b000};
      tbl[8]  = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 3'b000};
      tbl[9]  = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 3'b000};
      tbl[10] = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 3'b000};
      tbl[11] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 3'b000};
      tbl[12] = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 3'b000};

      repeat (2) @(posedge SCLK);
      #1;
      chk("reset_outputs", {24'd0, read_FIFO_en, dfi_rddata_valid, fifo_flush, outstanding,
          skew_err, timeout_err, ovf_err} & 32'hff, 32'd0);
      reset_n = 1;

      for (int i = 0; i < 13; i++) apply_vec(tbl[i]);

      // streaming: 8 pushes, pops over the last 4 pushes and 4 cycles after
      do_reset();
      vld_cnt = 0;
      for (int i = 0; i < 12; i++) cyc(i < 8, (i >= 4) ? 2'b11 : 2'b00, 1'b0);
      cyc(1'b0, 2'b00, 1'b0);
      chk("stream_valid_pulses", vld_cnt, 8);
      chk("stream_end_outstanding", {28'd0, outstanding}, 0);

      // lane skew with one beat owed
      do_reset();
      rd_seen = 0;
      cyc(1'b1, 2'b00, 1'b0);
      for (int i = 0; i < 15; i++) cyc(1'b0, 2'b01, 1'b0);
      chk("skew_before_limit", {31'd0, skew_err}, 0);
      cyc(1'b0, 2'b01, 1'b0);
      chk("skew_at_limit", {30'd0, skew_err, fifo_flush}, 32'd3);
      chk("skew_no_pop", {31'd0, rd_seen}, 0);

      // timeout with two beats owed, then recovery
      do_reset();
      cyc(1'b1, 2'b00, 1'b0);
      cyc(1'b1, 2'b00, 1'b0);
      for (int i = 0; i < 62; i++) cyc(1'b0, 2'b00, 1'b0);
      chk("timeout_before_limit", {31'd0, timeout_err}, 0);
      cyc(1'b0, 2'b00, 1'b0);
      cyc(1'b0, 2'b00, 1'b0);
      chk("timeout_at_limit", {31'd0, timeout_err}, 1);
      cyc(1'b1, 2'b11, 1'b0);
      cyc(1'b0, 2'b00, 1'b1);
      chk("clr_recovery", {24'd0, fifo_flush, outstanding, skew_err, timeout_err, ovf_err}
          & 32'hff, 32'd0);
      cyc(1'b0, 2'b11, 1'b0);

      // overflow
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1'b1, 2'b00, 1'b0);
      chk("ovf_full", {27'd0, ovf_err, outstanding}, 32'd8);
      cyc(1'b1, 2'b00, 1'b0);
      chk("ovf_set", {27'd0, ovf_err, outstanding}, 32'h18);
      cyc(1'b1, 2'b11, 1'b0);
      cyc(1'b0, 2'b00, 1'b1);

      // spurious data in idle, then async reset mid-stream
      do_reset();
      cyc(1'b0, 2'b11, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 2'b00, 1'b0);
      entries_in_FIFO_N = 2'b11;
      #1;
      reset_n = 0;
      #1;
      chk("async_reset", {24'd0, read_FIFO_en, dfi_rddata_valid, fifo_flush, outstanding,
          skew_err, timeout_err, ovf_err} & 32'hff, 32'd0);
      model_reset();
      entries_in_FIFO_N = '0;
      @(posedge SCLK); #1;
      reset_n = 1;

      // random traffic, alternating light and heavy request rates
      for (int i = 0; i < 3000; i++) begin
         int r;
         int pen;
         logic [1:0] ln;
         pen = ((i / 500) % 2 == 1) ? 70 : 35;
         r = $urandom_range(0, 9);
         ln = (r < 4) ? 2'b00 : (r < 8) ? 2'b11 : (r == 8) ? 2'b01 : 2'b10;
         cyc($urandom_range(0, 99) < pen, ln, $urandom_range(0, 19) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rd_lane_sched.md
# rd_lane_sched

Read-return scheduler between the DFI read path and the per-lane read FIFOs. It tracks read beats requested via `dfi_rddata_en` and releases `read_FIFO_en` only when a beat is outstanding and every DQS lane FIFO holds data. It generates `dfi_rddata_valid` one cycle after each release. It supervises lane skew, return timeout and outstanding-count overflow, and forces a FIFO flush on error.

## Interface
- `IOG_DQS_LANES`, default 2: number of DQS lanes / read FIFOs.
- `MAX_OUTSTANDING`, default 8: maximum read beats in flight. Counter width `CNT_W = clog2(MAX_OUTSTANDING+1)`.
- `SKEW_LIMIT`, default 16: cycles allowed with some-but-not-all lanes non-empty.
- `TIMEOUT_CYCLES`, default 64: cycles allowed with beats outstanding and no FIFO pop.
- `SCLK` in 1: system clock; all logic rises on `SCLK`.
- `reset_n` in 1: asynchronous, active-low reset.
- `dfi_rddata_en` in 1: one read beat requested this cycle.
- `entries_in_FIFO_N` in `IOG_DQS_LANES`: one bit per lane, high = lane FIFO holds at least one entry.
- `clr_err` in 1: single-cycle pulse; clears errors and leaves ERROR.
- `read_FIFO_en` out 1: pop all lane FIFOs this cycle (combinational).
- `dfi_rddata_valid` out 1: registered; read data valid to the controller.
- `fifo_flush` out 1: registered; flush all lane FIFOs.
- `outstanding` out `CNT_W`: registered count of beats in flight.
- `skew_err`, `timeout_err`, `ovf_err` out 1 each: registered, sticky error flags.

## Operation
- Reset values: all registered outputs and counters are 0; state is IDLE.
- States:
  - IDLE: `outstanding == 0`.
  - ACTIVE: `outstanding > 0`.
  - ERROR: any error flag set.
- `all_rdy = &entries_in_FIFO_N`; `any_rdy = |entries_in_FIFO_N`.
- `read_FIFO_en = (state == ACTIVE) && all_rdy`. It is never asserted in IDLE or ERROR, even when `all_rdy` is high.
- Outstanding counter:
  - +1 on `dfi_rddata_en` alone; −1 on `read_FIFO_en` alone.
  - Both together: the counter is unchanged.
  - `dfi_rddata_en` while `outstanding == MAX_OUTSTANDING` and no pop: the counter holds, `ovf_err` is set, and the state goes to ERROR.
- Transitions:
  - IDLE→ACTIVE on increment.
  - ACTIVE→IDLE when the count reaches 0.
  - Any state→ERROR when an error sets. Error detection has priority over the IDLE/ACTIVE transitions in the same cycle.
- Skew counter:
  - Increments each cycle `any_rdy && !all_rdy` outside ERROR; cleared otherwise.
  - On reaching `SKEW_LIMIT`, sets `skew_err` and goes to ERROR.
- Timeout counter:
  - Increments each ACTIVE cycle without `read_FIFO_en`; cleared on a pop or outside ACTIVE.
  - On reaching `TIMEOUT_CYCLES`, sets `timeout_err` and goes to ERROR.
- In ERROR:
  - `fifo_flush` = 1 and `read_FIFO_en` = 0.
  - `dfi_rddata_en` is ignored, and the counter holds its value.
- `clr_err` in ERROR:
  - Next cycle: all error flags, counters and `outstanding` are 0, `fifo_flush` = 0, and the state is IDLE.
  - `clr_err` outside ERROR has no effect.

## Timing
- `read_FIFO_en` has zero latency from `entries_in_FIFO_N` once in ACTIVE.
- `dfi_rddata_valid(n+1) = read_FIFO_en(n)`, exactly one cycle later.
- `outstanding` reflects the increment/decrement one cycle after the causing event.
- An error flag and the ERROR state appear on the same edge the limit is reached. `fifo_flush` rises on that edge.
- Back-to-back pops are allowed every cycle. Sustained throughput is 1 beat per cycle with simultaneous push/pop.
- A `reset_n` assertion mid-burst immediately zeroes all registered outputs, asynchronously. `read_FIFO_en` drops because state becomes IDLE.

## Test plan
- **Single beat:** pulse `dfi_rddata_en`, then 3 cycles later set `entries_in_FIFO_N = 2'b11` for 1 cycle. Required: `read_FIFO_en` high for that cycle, then `dfi_rddata_valid` high for 1 cycle, and `outstanding` goes 1→0.
- **Streaming:** 8 consecutive `dfi_rddata_en`, then all lanes ready for 8 cycles, with push and pop overlapping on 4 of those cycles. Required: `outstanding` never exceeds 8, ends at 0, and exactly 8 `dfi_rddata_valid` pulses occur.
- **Lane skew:** 1 beat outstanding, `entries_in_FIFO_N = 2'b01` held 16 cycles. Required: `skew_err` and `fifo_flush` are 1 on the 16th cycle, and `read_FIFO_en` is never asserted.
- **Timeout and recovery:** 2 beats outstanding, no lanes ready for 64 cycles. Required: `timeout_err` = 1. Then pulse `clr_err`; next cycle all flags = 0, `outstanding` = 0, IDLE.
- **Overflow:** 9 `dfi_rddata_en` with no data. Required: `ovf_err` = 1 on the 9th, and `outstanding` stays 8.
- **Spurious data and reset:** in IDLE set `entries_in_FIFO_N = 2'b11`. Required: `read_FIFO_en` = 0. Then, with 3 beats outstanding, assert `reset_n` = 0 mid-stream. Required: all outputs 0 immediately.
